pmem_arbiter: RTL

Parametrised arbiter that multiplexes NUM_PORTS cache-line requesters (split L1 I/D caches, future L2 or victim buffer) onto the single physical-memory port at the top of the lc3b MP3 memory hierarchy. It latches one request at a time and forwards it to pmem under round-robin or fixed-priority selection. It routes the response back to the winning port. It also watches for memory stalls with a timeout counter and flags protocol errors.

---
 rtl/pmem_arbiter_if.sv | 31 +++
 rtl/pmem_arbiter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/pmem_arbiter_if.sv
// Requester-side and physical-memory-side signals of the pmem arbiter.
// The arbiter uses the slave view; the requester/memory side uses the master view.
interface pmem_arbiter_if #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
);
    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] req_address;
    logic [NUM_PORTS-1:0]                 req_read;
    logic [NUM_PORTS-1:0]                 req_write;
    logic [NUM_PORTS-1:0][LINE_WIDTH-1:0] req_wdata;
    logic [NUM_PORTS-1:0]                 req_resp;
    logic [LINE_WIDTH-1:0]                req_rdata;

    logic [ADDR_WIDTH-1:0]                pmem_address;
    logic                                 pmem_read;
    logic                                 pmem_write;
    logic [LINE_WIDTH-1:0]                pmem_wdata;
    logic                                 pmem_resp;
    logic [LINE_WIDTH-1:0]                pmem_rdata;

    modport slave (
        input  req_address, req_read, req_write, req_wdata, pmem_resp, pmem_rdata,
        output req_resp, req_rdata, pmem_address, pmem_read, pmem_write, pmem_wdata
    );

    modport master (
        output req_address, req_read, req_write, req_wdata, pmem_resp, pmem_rdata,
        input  req_resp, req_rdata, pmem_address, pmem_read, pmem_write, pmem_wdata
    );
endinterface

// File: rtl/pmem_arbiter.sv
// Arbitrates NUM_PORTS cache-line requesters onto one physical-memory port,
// one latched transaction at a time, with stall timeout and protocol-error flags.
module pmem_arbiter #(
    parameter int NUM_PORTS      = 2,
    parameter int ADDR_WIDTH     = 16,
    parameter int LINE_WIDTH     = 128,
    parameter int RR_MODE        = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                         clk,
    input  logic                         rst_n,
    pmem_arbiter_if.slave                bus,
    output logic [$clog2(NUM_PORTS)-1:0] grant_id,
    output logic                         busy,
    output logic                         timeout,
    output logic                         proto_err
);
    localparam int GW = $clog2(NUM_PORTS);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                state_reg;
    logic [GW-1:0]         rr_ptr_reg;
    logic [GW-1:0]         grant_id_reg;
    logic [CW-1:0]         cnt_reg;
    logic [ADDR_WIDTH-1:0] pmem_address_reg;
    logic [LINE_WIDTH-1:0] pmem_wdata_reg;
    logic                  pmem_read_reg;
    logic                  pmem_write_reg;
    logic                  timeout_reg;
    logic                  proto_err_reg;

    logic [NUM_PORTS-1:0]  pending;
    logic [GW-1:0]         start_idx;
    logic [GW-1:0]         scan_idx;
    logic [GW:0]           scan_wide;
    logic [GW-1:0]         winner;
    logic                  found;

    assign pending = bus.req_read | bus.req_write;

    // First pending port at or after start_idx, wrapping; fixed priority starts at 0.
    always_comb begin
        winner    = '0;
        found     = 1'b0;
        scan_idx  = '0;
        scan_wide = '0;
        start_idx = (RR_MODE != 0) ? rr_ptr_reg : '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            scan_wide = {1'b0, start_idx} + (GW+1)'(k);
            if (scan_wide >= (GW+1)'(NUM_PORTS))
                scan_wide = scan_wide - (GW+1)'(NUM_PORTS);
            scan_idx = scan_wide[GW-1:0];
            if (!found && pending[scan_idx]) begin
                winner = scan_idx;
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            rr_ptr_reg       <= '0;
            grant_id_reg     <= '0;
            cnt_reg          <= '0;
            pmem_address_reg <= '0;
            pmem_wdata_reg   <= '0;
            pmem_read_reg    <= 1'b0;
            pmem_write_reg   <= 1'b0;
            timeout_reg      <= 1'b0;
            proto_err_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (found) begin
                        pmem_address_reg <= bus.req_address[winner];
                        pmem_wdata_reg   <= bus.req_wdata[winner];
                        // Read+write together resolves to a write.
                        pmem_write_reg   <= bus.req_write[winner];
                        pmem_read_reg    <= ~bus.req_write[winner];
                        grant_id_reg     <= winner;
                        cnt_reg          <= '0;
                        if (RR_MODE != 0)
                            rr_ptr_reg <= (int'(winner) == NUM_PORTS - 1) ? '0 : winner + 1'b1;
                        if (bus.req_read[winner] && bus.req_write[winner])
                            proto_err_reg <= 1'b1;
                        state_reg <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.pmem_resp) begin
                        pmem_read_reg  <= 1'b0;
                        pmem_write_reg <= 1'b0;
                        state_reg      <= IDLE;
                    end else begin
                        if (cnt_reg != CW'(TIMEOUT_CYCLES))
                            cnt_reg <= cnt_reg + 1'b1;
                        if (cnt_reg == CW'(TIMEOUT_CYCLES - 1))
                            timeout_reg <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Completion is steered combinationally so the requester sees it in the pmem_resp cycle.
    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_resp
            assign bus.req_resp[gi] = (state_reg == BUSY) && bus.pmem_resp
                                      && (grant_id_reg == GW'(gi));
        end
    endgenerate

    assign bus.req_rdata    = bus.pmem_rdata;
    assign bus.pmem_address = pmem_address_reg;
    assign bus.pmem_wdata   = pmem_wdata_reg;
    assign bus.pmem_read    = pmem_read_reg;
    assign bus.pmem_write   = pmem_write_reg;
    assign grant_id         = grant_id_reg;
    assign busy             = (state_reg == BUSY);
    assign timeout          = timeout_reg;
    assign proto_err        = proto_err_reg;
endmodule
